// File: rtl/win_mom.sv
// Sliding-window mean and variance over the last WINDOW unsigned samples, 3-stage pipeline.
// Optional macro WIN_MOM_ROUND_EN: round-to-nearest mean (saturating) instead of truncation.
module win_mom #(
   parameter int DATA_W = 8,
   parameter int WINDOW = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_in_valid,
   input  logic [DATA_W-1:0]     i_data_in,
   input  logic                  i_clear,
   output logic                  o_out_valid,
   output logic [DATA_W-1:0]     o_mean,
   output logic [2*DATA_W-1:0]   o_var,
   output logic                  o_window_full
);

   localparam int LOG2W = $clog2(WINDOW);
   localparam int SW    = DATA_W + LOG2W;
   localparam int QW    = 2*DATA_W + LOG2W;
   localparam int PW    = 2*SW;
   localparam int FW    = LOG2W + 1;

   logic [DATA_W-1:0]   r_buf [WINDOW];
   logic [LOG2W-1:0]    r_ptr;
   logic [FW-1:0]       r_fill;
   logic [SW-1:0]       r_sum;
   logic [QW-1:0]       r_sq;
   logic                r_v1;

   logic [PW-1:0]       r_pa;
   logic [PW-1:0]       r_pb;
   logic [SW-1:0]       r_sum_d;
   logic                r_v2;

   logic [DATA_W-1:0]   w_old;
   logic [QW-1:0]       w_old_sq;
   logic [QW-1:0]       w_new_sq;
   logic [SW-1:0]       w_sum_nxt;
   logic [QW-1:0]       w_sq_nxt;
   logic [LOG2W-1:0]    w_ptr_nxt;
   logic [FW-1:0]       w_fill_nxt;
   logic [PW-1:0]       w_diff;
   logic [2*DATA_W-1:0] w_var;
   logic [DATA_W-1:0]   w_mean;

`ifdef WIN_MOM_ROUND_EN
   localparam logic [SW:0] HALF_W   = (SW+1)'(WINDOW/2);
   localparam logic [SW:0] MEAN_MAX = (SW+1)'((1 << DATA_W) - 1);
   logic [SW:0] w_mean_sh;
`endif

   // Next-state arithmetic for the running moments, pointer and fill count, plus output math
   always_comb begin
      w_old     = r_buf[r_ptr];
      w_new_sq  = QW'(i_data_in) * QW'(i_data_in);
      w_old_sq  = QW'(w_old) * QW'(w_old);
      // The evicted slot is already part of the sums, so the subtraction never underflows
      w_sum_nxt = r_sum + SW'(i_data_in) - SW'(w_old);
      w_sq_nxt  = r_sq + w_new_sq - w_old_sq;
      if (r_ptr == LOG2W'(WINDOW - 1)) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = r_ptr + LOG2W'(1);
      end
      if (r_fill == FW'(WINDOW)) begin
         w_fill_nxt = r_fill;
      end else begin
         w_fill_nxt = r_fill + FW'(1);
      end
      w_diff = r_pa - r_pb;
      w_var  = (2*DATA_W)'(w_diff >> (2*LOG2W));
`ifdef WIN_MOM_ROUND_EN
      w_mean_sh = ({1'b0, r_sum_d} + HALF_W) >> LOG2W;
      if (w_mean_sh > MEAN_MAX) begin
         w_mean = '1;
      end else begin
         w_mean = DATA_W'(w_mean_sh);
      end
`else
      w_mean = DATA_W'(r_sum_d >> LOG2W);
`endif
   end

   // Stage 1: ring buffer, running sums and fill tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WINDOW; i++) r_buf[i] <= '0;
         r_ptr         <= '0;
         r_fill        <= '0;
         r_sum         <= '0;
         r_sq          <= '0;
         r_v1          <= 1'b0;
         o_window_full <= 1'b0;
      end else if (i_clear) begin
         for (int i = 0; i < WINDOW; i++) r_buf[i] <= '0;
         r_ptr         <= '0;
         r_fill        <= '0;
         r_sum         <= '0;
         r_sq          <= '0;
         r_v1          <= 1'b0;
         o_window_full <= 1'b0;
      end else if (i_in_valid) begin
         r_buf[r_ptr]  <= i_data_in;
         r_ptr         <= w_ptr_nxt;
         r_fill        <= w_fill_nxt;
         r_sum         <= w_sum_nxt;
         r_sq          <= w_sq_nxt;
         r_v1          <= 1'b1;
         o_window_full <= (w_fill_nxt == FW'(WINDOW));
      end else begin
         r_v1          <= 1'b0;
      end
   end

   // Stage 2: WINDOW*sqsum and sum*sum products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pa    <= '0;
         r_pb    <= '0;
         r_sum_d <= '0;
         r_v2    <= 1'b0;
      end else if (i_clear) begin
         r_pa    <= '0;
         r_pb    <= '0;
         r_sum_d <= '0;
         r_v2    <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_pa    <= PW'(r_sq) << LOG2W;
            r_pb    <= PW'(r_sum) * PW'(r_sum);
            r_sum_d <= r_sum;
         end
      end
   end

   // Stage 3: registered mean/variance, held between valid pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_out_valid <= 1'b0;
         o_mean      <= '0;
         o_var       <= '0;
      end else if (i_clear) begin
         o_out_valid <= 1'b0;
         o_mean      <= '0;
         o_var       <= '0;
      end else begin
         o_out_valid <= r_v2;
         if (r_v2) begin
            o_mean <= w_mean;
            o_var  <= w_var;
         end
      end
   end

endmodule

// File: tb/tb_win_mom.sv
// Directed table-driven bench for win_mom (DATA_W=8, WINDOW=4), both mean-rounding builds.
module tb_win_mom;

   logic        clk;
   logic        rst_n;
   logic        i_in_valid;
   logic [7:0]  i_data_in;
   logic        i_clear;
   logic        o_out_valid;
   logic [7:0]  o_mean;
   logic [15:0] o_var;
   logic        o_window_full;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        clr;
      logic        vld;
      logic [7:0]  din;
      logic        ov;
      logic [7:0]  m_t;
      logic [7:0]  m_r;
      logic [15:0] vr;
      logic        full;
   } vec_t;

   vec_t tv[$];

   win_mom #(.DATA_W(8), .WINDOW(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_in_valid    (i_in_valid),
      .i_data_in     (i_data_in),
      .i_clear       (i_clear),
      .o_out_valid   (o_out_valid),
      .o_mean        (o_mean),
      .o_var         (o_var),
      .o_window_full (o_window_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic c, input logic v, input int d, input logic ov,
                      input int mt, input int mr, input int vr, input logic full);
      vec_t e;
      e.clr = c; e.vld = v; e.din = 8'(d); e.ov = ov;
      e.m_t = 8'(mt); e.m_r = 8'(mr); e.vr = 16'(vr); e.full = full;
      tv.push_back(e);
   endtask

   task automatic drive(input logic c, input logic v, input int d);
      i_clear    = c;
      i_in_valid = v;
      i_data_in  = 8'(d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_mean;
      rst_n = 1'b0; i_in_valid = 1'b0; i_data_in = 8'd0; i_clear = 1'b0;

      // 10,10,10,10 from reset
      add(0,1,10, 0,0,0,0,0);
      add(0,1,10, 0,0,0,0,0);
      add(0,1,10, 1,2,3,18,0);
      add(0,1,10, 1,5,5,25,1);
      add(0,0,0,  1,7,8,18,1);
      add(0,0,0,  1,10,10,0,1);
      add(0,0,0,  0,10,10,0,1);
      add(1,0,0,  0,0,0,0,0);
      // single sample 8
      add(0,1,8,  0,0,0,0,0);
      add(0,0,0,  0,0,0,0,0);
      add(0,0,0,  1,2,2,12,0);
      add(0,0,0,  0,2,2,12,0);
      add(1,0,0,  0,0,0,0,0);
      // 0,4,0,4 then 255 x4 (pointer wrap, fill saturation, max magnitude)
      add(0,1,0,  0,0,0,0,0);
      add(0,1,4,  0,0,0,0,0);
      add(0,1,0,  1,0,0,0,0);
      add(0,1,4,  1,1,1,3,1);
      add(0,1,255,1,1,1,3,1);
      add(0,1,255,1,2,2,4,1);
      add(0,1,255,1,65,66,11941,1);
      add(0,1,255,1,128,129,16004,1);
      add(0,0,0,  1,192,192,11812,1);
      add(0,0,0,  1,255,255,0,1);
      add(0,0,0,  0,255,255,0,1);
      add(1,0,0,  0,0,0,0,0);
      // 2,0,0,0: truncate vs round
      add(0,1,2,  0,0,0,0,0);
      add(0,1,0,  0,0,0,0,0);
      add(0,1,0,  1,0,1,0,0);
      add(0,1,0,  1,0,1,0,1);
      add(0,0,0,  1,0,1,0,1);
      add(0,0,0,  1,0,1,0,1);
      add(0,0,0,  0,0,1,0,1);
      add(1,0,0,  0,0,0,0,0);
      // clear with in_valid while two samples in flight, then sample 4
      add(0,1,7,  0,0,0,0,0);
      add(0,1,9,  0,0,0,0,0);
      add(1,1,50, 0,0,0,0,0);
      add(0,0,0,  0,0,0,0,0);
      add(0,0,0,  0,0,0,0,0);
      add(0,1,4,  0,0,0,0,0);
      add(0,0,0,  0,0,0,0,0);
      add(0,0,0,  1,1,1,3,0);
      add(0,0,0,  0,1,1,3,0);

      #12;
      check("reset out_valid", {31'd0, o_out_valid}, 32'd0);
      check("reset mean", {24'd0, o_mean}, 32'd0);
      check("reset var", {16'd0, o_var}, 32'd0);
      check("reset window_full", {31'd0, o_window_full}, 32'd0);
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].clr, tv[i].vld, int'(tv[i].din));
`ifdef WIN_MOM_ROUND_EN
         exp_mean = tv[i].m_r;
`else
         exp_mean = tv[i].m_t;
`endif
         check($sformatf("row%0d out_valid", i), {31'd0, o_out_valid}, {31'd0, tv[i].ov});
         check($sformatf("row%0d mean", i), {24'd0, o_mean}, {24'd0, exp_mean});
         check($sformatf("row%0d var", i), {16'd0, o_var}, {16'd0, tv[i].vr});
         check($sformatf("row%0d window_full", i), {31'd0, o_window_full}, {31'd0, tv[i].full});
      end

      // asynchronous reset mid-stream, with results still in flight
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 100);
      check("prereset window_full", {31'd0, o_window_full}, 32'd1);
      i_in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("async out_valid", {31'd0, o_out_valid}, 32'd0);
      check("async mean", {24'd0, o_mean}, 32'd0);
      check("async var", {16'd0, o_var}, 32'd0);
      check("async window_full", {31'd0, o_window_full}, 32'd0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 0);
         check($sformatf("postreset idle%0d out_valid", k), {31'd0, o_out_valid}, 32'd0);
      end
      drive(1'b0, 1'b1, 8);
      drive(1'b0, 1'b0, 0);
      drive(1'b0, 1'b0, 0);
      check("postreset out_valid", {31'd0, o_out_valid}, 32'd1);
      check("postreset mean", {24'd0, o_mean}, 32'd2);
      check("postreset var", {16'd0, o_var}, 32'd12);
      check("postreset window_full", {31'd0, o_window_full}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/win_mom.md
WIN_MOM -- requirements
Module: win_mom

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning unsigned input sample width (2..16).
REQ-002 SHALL provide parameter WINDOW, default 4, meaning sliding-window depth in samples (power of two, 2..256; LOG2W = log2(WINDOW)).
REQ-003 SHALL provide port clk  input  1  single rising-edge clock.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port in_valid  input  1  sample qualifier; sample accepted on every rising edge where high.
REQ-006 SHALL provide port data_in  input  DATA_W  unsigned sample.
REQ-007 SHALL provide port clear  input  1  synchronous flush of window and pipeline.
REQ-008 SHALL provide port out_valid  output  1  one-cycle pulse marking valid mean/var.
REQ-009 SHALL provide port mean  output  DATA_W  window mean.
REQ-010 SHALL provide port var  output  2*DATA_W  window variance (second central moment).
REQ-011 SHALL provide port window_full  output  1  high once WINDOW samples accepted since reset/clear.

Function
REQ-012 SHALL hold the last WINDOW accepted samples in a ring buffer; unfilled slots read as zero.
REQ-013 SHALL maintain running sum (DATA_W+LOG2W bits) and running sum of squares (2*DATA_W+LOG2W bits), each updated per accepted sample by adding the new term and subtracting the evicted slot's term, never overflowing.
REQ-014 SHALL compute var = (WINDOW*sqsum - sum*sum) >> (2*LOG2W), exact integer, result always non-negative and fitting 2*DATA_W bits.
REQ-015 SHALL compute mean = sum >> LOG2W (truncating) unless modified by REQ-024.
REQ-016 SHALL be a 3-stage pipeline: edge N registers sums for sample accepted at edge N, edge N+1 registers products, edge N+2 registers mean/var with out_valid high for exactly one cycle.
REQ-017 SHALL accept back-to-back samples every cycle with no stall; out_valid pulses track in_valid pattern delayed two edges.
REQ-018 SHALL hold mean/var stable between out_valid pulses.
REQ-019 SHALL assert window_full on the edge accepting the WINDOW-th sample and keep it high until reset/clear; fill counter saturates at WINDOW.
REQ-020 SHALL, on clear high at an edge: zero buffer, sums, fill counter, pointer, mean, var; drop in-flight pipeline results (out_valid low next cycle and for the following two cycles unless new samples arrive); clear wins over simultaneous in_valid (sample dropped).
REQ-021 SHALL wrap the write pointer from WINDOW-1 to 0.

Reset
REQ-022 SHALL, while rst_n low, asynchronously force out_valid=0, mean=0, var=0, window_full=0, sums, buffer, pointer, fill counter and pipeline valids to 0.
REQ-023 SHALL release reset synchronously on the first clk edge after rst_n high; first sample may be accepted on that edge.

Configuration
REQ-024 SHALL, when macro WIN_MOM_ROUND_EN is defined, compute mean = (sum + WINDOW/2) >> LOG2W, saturated to 2^DATA_W-1; when undefined, mean truncates per REQ-015; var unaffected in both cases.

Verification (DATA_W=8, WINDOW=4)
REQ-025 SHALL check: reset, in_valid 10,10,10,10 consecutive -> 4th out_valid pulse (2 edges after 4th sample) gives mean=10, var=0, window_full=1.
REQ-026 SHALL check: reset, single sample 8 -> out_valid after 2 edges, mean=2, var=12, window_full=0.
REQ-027 SHALL check: samples 0,4,0,4 -> final mean=2, var=4; then 255 x4 -> mean=255, var=0 (no overflow).
REQ-028 SHALL check: samples 2,0,0,0 -> mean=0 without WIN_MOM_ROUND_EN, mean=1 with it; var=0 both builds.
REQ-029 SHALL check: clear asserted with in_valid in the cycle after two samples in flight -> no out_valid for dropped/in-flight samples, mean=var=0, window_full=0; next sample 4 -> mean=1, var=3.
REQ-030 SHALL check: rst_n pulsed low mid-stream asynchronously (between edges) -> all outputs 0 immediately, no out_valid after release until new samples accepted.
